oc_bc_csr_responder: RTL
========================

OC_BC_CSR_RESPONDER -- requirements
Module: oc_bc_csr_responder

Interface
REQ-001 SHALL have parameter CsrType, default oclib_pkg::bc_8b_bidi_s, the type of the inbound byte-channel struct.
REQ-002 SHALL have parameter CsrFbType, default oclib_pkg::bc_8b_bidi_s, the type of the outbound byte-channel struct.
REQ-003 SHALL have parameter RegTimeoutCycles, default 1024, the maximum number of cycles to wait for regAck.
REQ-004 SHALL have parameter FrameTimeoutCycles, default 65536, the maximum idle gap between request bytes inside one frame.
REQ-005 SHALL have port clock, input, 1 bit: the single clock for all logic.
REQ-006 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port csr, input, CsrType: request byte (csr.data, csr.valid) and response-accept (csr.ready).
REQ-008 SHALL have port csrFb, output, CsrFbType: response byte (csrFb.data, csrFb.valid) and request-accept (csrFb.ready).
REQ-009 SHALL have port regAddr, output, 16 bits: local register address.
REQ-010 SHALL have port regWdata, output, 32 bits: local write data.
REQ-011 SHALL have port regWrite, output, 1 bit: write strobe, held until ack or timeout.
REQ-012 SHALL have port regRead, output, 1 bit: read strobe, held until ack or timeout.
REQ-013 SHALL have port regAck, input, 1 bit: access complete; regRdata and regError are valid in the same cycle.
REQ-014 SHALL have port regRdata, input, 32 bits: local read data.
REQ-015 SHALL have port regError, input, 1 bit: the access failed.

Function
REQ-016 SHALL transfer a byte in either direction only on a cycle where valid and ready are both 1.
- Request path: csr.valid with csrFb.ready.
- Response path: csrFb.valid with csr.ready.
REQ-017 SHALL use the following request frame.
- Byte 0: command; 0x01 = write, 0x02 = read.
- Bytes 1-2: address, MSB first.
- Write only: bytes 3-6 carry data, MSB first.
REQ-018 SHALL use the following response frame.
- Byte 0: status; 0x00 = OK, 0x01 = bad command, 0x02 = timeout, 0x03 = regError.
- Read with status 0x00 only: 4 data bytes follow, MSB first.
REQ-019 SHALL implement the states IDLE, ADDR, WDATA, ACCESS, RSTATUS and RDATA.
- A 3-bit byte counter indexes multi-byte fields.
REQ-020 SHALL transition from IDLE as follows on accepting a byte.
- 0x01 or 0x02: go to ADDR.
- Any other value: go to RSTATUS with status 0x01, no register access.
REQ-021 SHALL transition from ADDR after 2 bytes.
- Write: go to WDATA.
- Read: go to ACCESS.
REQ-022 SHALL go from WDATA to ACCESS after 4 bytes.
REQ-023 SHALL drive csrFb.ready = 1 only in IDLE, ADDR and WDATA.
REQ-024 SHALL behave as follows in ACCESS.
- Assert exactly one of regWrite/regRead from the first ACCESS cycle, with regAddr and regWdata stable, until regAck or timeout.
- Deassert the strobe in the cycle after regAck.
REQ-025 SHALL capture regRdata and status (0x03 if regError, else 0x00) on regAck, then go to RSTATUS.
REQ-026 SHALL count ACCESS cycles and, if RegTimeoutCycles elapse without regAck, drop the strobe and go to RSTATUS with status 0x02.
- A regAck arriving in the same cycle as expiry SHALL win, giving status 0x00 or 0x03.
REQ-027 SHALL hold csrFb.valid = 1 with a stable csrFb.data in RSTATUS and RDATA until accepted.
- csrFb.data SHALL NOT change while valid and not accepted.
REQ-028 SHALL leave RSTATUS on acceptance as follows.
- Read with status 0x00: go to RDATA.
- Otherwise: go to IDLE.
REQ-029 SHALL go from RDATA to IDLE after 4 accepted bytes.
REQ-030 SHALL, in ADDR or WDATA, count cycles with no accepted byte; at FrameTimeoutCycles it SHALL discard the partial frame and return to IDLE with no response and no access.
- The counter resets on each accepted byte.
REQ-031 SHALL accept a new request byte no earlier than the cycle after the last response byte is accepted (no overlap of frames).
REQ-032 SHALL size all counters to hold the maximum of their parameters; counters SHALL saturate, never wrap.

Reset
REQ-033 SHALL, on reset, set the state to IDLE and clear counters, captured data and status.
REQ-034 SHALL, during and after reset, hold csrFb.valid = 0, csrFb.data = 0x00, regWrite = 0, regRead = 0, regAddr = 0 and regWdata = 0.
REQ-035 SHALL hold csrFb.ready = 0 while reset is asserted and = 1 in the first cycle after reset deasserts.
REQ-036 SHALL, on reset asserted mid-frame or mid-access, abandon the frame with no response and drop any strobe in the next cycle.

Verification
REQ-037 SHALL cover a write: bytes 01 12 34 DE AD BE EF, regAck after 3 cycles -> regWrite with regAddr 0x1234 and regWdata 0xDEADBEEF, then response 00.
REQ-038 SHALL cover a read: bytes 02 00 10, regAck with regRdata 0xCAFEF00D -> response 00 CA FE F0 0D, with csr.ready toggled randomly and data held stable while stalled.
REQ-039 SHALL cover a bad command: byte 07 -> response 01 with no regRead or regWrite, then the next frame is processed normally.
REQ-040 SHALL cover an access timeout: a read with regAck never asserted and RegTimeoutCycles = 16 -> strobe drops after 16 cycles and the response is 02; a separate case with regError = 1 on ack -> response 03.
REQ-041 SHALL cover a frame timeout: bytes 01 12 then silence for FrameTimeoutCycles -> no access and no response, and a subsequent 02 00 00 read completes.
REQ-042 SHALL cover reset mid-access: reset pulsed while regRead = 1 -> all outputs at reset values the following cycle and no response byte emitted.

Source files
------------

// File: rtl/oclib_pkg.sv
// Shared byte-channel types for the CSR transport.
// Latency: n/a (type definitions only).
// Backpressure: n/a; each bidirectional channel carries its own valid/ready pair.
package oclib_pkg;

    // One byte each way: data/valid travel forward, ready travels back.
    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       ready;
    } bc_8b_bidi_s;

endpackage

// File: rtl/oc_bc_csr_responder.sv
// Byte-serial CSR responder: decodes write/read frames into one local register access and returns a status (+ read data) frame.
// Latency: access strobe in the cycle after the last request byte; status byte valid the cycle after regAck or timeout.
// Backpressure: request bytes accepted only in IDLE/ADDR/WDATA; response bytes held stable until csr.ready.
module oc_bc_csr_responder #(
    parameter type CsrType            = oclib_pkg::bc_8b_bidi_s,
    parameter type CsrFbType          = oclib_pkg::bc_8b_bidi_s,
    parameter int  RegTimeoutCycles   = 1024,
    parameter int  FrameTimeoutCycles = 65536
) (
    input  logic        clock,
    input  logic        reset,
    input  CsrType      csr,
    output CsrFbType    csrFb,
    output logic [15:0] regAddr,
    output logic [31:0] regWdata,
    output logic        regWrite,
    output logic        regRead,
    input  logic        regAck,
    input  logic [31:0] regRdata,
    input  logic        regError
);

    localparam int RegCntW   = $clog2(RegTimeoutCycles + 1);
    localparam int FrameCntW = $clog2(FrameTimeoutCycles + 1);
    localparam logic [RegCntW-1:0]   RegLast   = RegCntW'(RegTimeoutCycles - 1);
    localparam logic [FrameCntW-1:0] FrameLast = FrameCntW'(FrameTimeoutCycles - 1);

    localparam logic [7:0] CmdWrite  = 8'h01;
    localparam logic [7:0] CmdRead   = 8'h02;
    localparam logic [7:0] StOk      = 8'h00;
    localparam logic [7:0] StBadCmd  = 8'h01;
    localparam logic [7:0] StTimeout = 8'h02;
    localparam logic [7:0] StRegErr  = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        ACCESS,
        RSTATUS,
        RDATA
    } stateT;

    stateT                state;
    stateT                stateNext;
    logic [2:0]           byteCnt;
    logic                 isRead;
    logic [15:0]          addrReg;
    logic [31:0]          wdataReg;
    logic [31:0]          rdataReg;
    logic [7:0]           status;
    logic [RegCntW-1:0]   regTimer;
    logic [FrameCntW-1:0] frameTimer;

    logic       reqRdy;
    logic       rspVld;
    logic [7:0] rspDat;
    logic       strobeWr;
    logic       strobeRd;
    logic       reqFire;
    logic       rspFire;
    logic       cmdValid;
    logic       regExpire;
    logic       frameExpire;

    assign cmdValid    = (csr.data == CmdWrite) || (csr.data == CmdRead);
    assign regExpire   = (regTimer == RegLast);
    assign frameExpire = (frameTimer == FrameLast);
    assign reqFire     = reqRdy && csr.valid;
    assign rspFire     = rspVld && csr.ready;

    // State register; reset abandons any frame or access in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode plus channel/strobe outputs, all forced to idle values while reset is high.
    always_comb begin
        stateNext = state;
        reqRdy    = 1'b0;
        rspVld    = 1'b0;
        rspDat    = 8'h00;
        strobeWr  = 1'b0;
        strobeRd  = 1'b0;
        case (state)
            IDLE: begin
                reqRdy = 1'b1;
                if (csr.valid) begin
                    stateNext = cmdValid ? ADDR : RSTATUS;
                end
            end
            ADDR: begin
                reqRdy = 1'b1;
                if (csr.valid) begin
                    if (byteCnt == 3'd1) begin
                        stateNext = isRead ? ACCESS : WDATA;
                    end
                end else if (frameExpire) begin
                    stateNext = IDLE;
                end
            end
            WDATA: begin
                reqRdy = 1'b1;
                if (csr.valid) begin
                    if (byteCnt == 3'd3) begin
                        stateNext = ACCESS;
                    end
                end else if (frameExpire) begin
                    stateNext = IDLE;
                end
            end
            ACCESS: begin
                strobeWr = !isRead;
                strobeRd = isRead;
                if (regAck || regExpire) begin
                    stateNext = RSTATUS;
                end
            end
            RSTATUS: begin
                rspVld = 1'b1;
                rspDat = status;
                if (csr.ready) begin
                    stateNext = (isRead && status == StOk) ? RDATA : IDLE;
                end
            end
            RDATA: begin
                rspVld = 1'b1;
                case (byteCnt[1:0])
                    2'd0:    rspDat = rdataReg[31:24];
                    2'd1:    rspDat = rdataReg[23:16];
                    2'd2:    rspDat = rdataReg[15:8];
                    default: rspDat = rdataReg[7:0];
                endcase
                if (csr.ready && byteCnt == 3'd3) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase

        if (reset) begin
            reqRdy   = 1'b0;
            rspVld   = 1'b0;
            rspDat   = 8'h00;
            strobeWr = 1'b0;
            strobeRd = 1'b0;
        end

        csrFb       = '0;
        csrFb.data  = rspDat;
        csrFb.valid = rspVld;
        csrFb.ready = reqRdy;
        regWrite    = strobeWr;
        regRead     = strobeRd;
        regAddr     = reset ? 16'h0000 : addrReg;
        regWdata    = reset ? 32'h0 : wdataReg;
    end

    // Frame assembly, access timing, and response capture; counters saturate rather than wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            byteCnt    <= '0;
            isRead     <= 1'b0;
            addrReg    <= '0;
            wdataReg   <= '0;
            rdataReg   <= '0;
            status     <= StOk;
            regTimer   <= '0;
            frameTimer <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqFire) begin
                        byteCnt    <= '0;
                        frameTimer <= '0;
                        if (cmdValid) begin
                            isRead <= (csr.data == CmdRead);
                        end else begin
                            isRead <= 1'b0;
                            status <= StBadCmd;
                        end
                    end
                end
                ADDR, WDATA: begin
                    if (reqFire) begin
                        frameTimer <= '0;
                        regTimer   <= '0;
                        if (state == ADDR) begin
                            addrReg <= {addrReg[7:0], csr.data};
                            byteCnt <= (byteCnt == 3'd1) ? 3'd0 : byteCnt + 3'd1;
                        end else begin
                            wdataReg <= {wdataReg[23:0], csr.data};
                            byteCnt  <= (byteCnt == 3'd3) ? 3'd0 : byteCnt + 3'd1;
                        end
                    end else if (frameTimer != '1) begin
                        frameTimer <= frameTimer + 1'b1;
                    end
                end
                ACCESS: begin
                    // An ack landing on the expiry cycle takes precedence over the timeout.
                    if (regAck) begin
                        rdataReg <= regRdata;
                        status   <= regError ? StRegErr : StOk;
                    end else if (regExpire) begin
                        status <= StTimeout;
                    end else if (regTimer != '1) begin
                        regTimer <= regTimer + 1'b1;
                    end
                end
                RSTATUS: begin
                    if (rspFire) begin
                        byteCnt <= '0;
                    end
                end
                RDATA: begin
                    if (rspFire) begin
                        byteCnt <= byteCnt + 3'd1;
                    end
                end
                default: byteCnt <= '0;
            endcase
        end
    end

endmodule
